// File: rtl/mc_pattern_pkg.sv
// Shared types and constants for the memory-controller pattern sequencer.
// Optional LFSR data source is enabled with macro MC_PATTERN_SEQ_LFSR_EN.
package mc_pattern_pkg;

  localparam int DEF_DATA_W = 31;
  localparam int DEF_DEPTH  = 9;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Galois feedback masks (right-shift form) for maximal-length LFSRs
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] t;
    case (w)
      8:       t = 64'h0000_0000_0000_00B8;
      16:      t = 64'h0000_0000_0000_B400;
      24:      t = 64'h0000_0000_00E1_0000;
      31:      t = 64'h0000_0000_4800_0000;
      32:      t = 64'h0000_0000_8020_0003;
      default: t = (64'd1 << (w - 1)) | 64'd1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mc_pattern_lfsr.sv
// Galois LFSR used as an alternative pattern data source.
// Only instantiated when MC_PATTERN_SEQ_LFSR_EN is defined.
module mc_pattern_lfsr
  import mc_pattern_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] value
);

  localparam logic [63:0]  TAPS64 = lfsr_taps(W);
  localparam logic [W-1:0] TAPS   = TAPS64[W-1:0];

  logic [W-1:0] val_q;

  // Load a nonzero seed, otherwise shift on each step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= W'(1);
    end else if (load) begin
      val_q <= (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      val_q <= {1'b0, val_q[W-1:1]} ^ (val_q[0] ? TAPS : '0);
    end
  end

  assign value = val_q;

endmodule

// File: rtl/mc_pattern_seq.sv
// Table-driven pattern sequencer feeding words to a memory controller.
// MC_PATTERN_SEQ_LFSR_EN adds lfsr_mode and an LFSR data source.
module mc_pattern_seq
  import mc_pattern_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
`ifdef MC_PATTERN_SEQ_LFSR_EN
  input  logic              lfsr_mode,
`endif
  input  logic              tbl_wr_en,
  input  logic [IDX_W-1:0]  tbl_wr_addr,
  input  logic [DATA_W-1:0] tbl_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [DATA_W-1:0] tbl_q [DEPTH];

  logic accept;
  logic last;
  logic wr_ok;
  logic go;

  assign accept = (state_q == S_RUN) && out_ready;
  assign last   = (idx_q == LAST);
  assign go     = start && (state_q != S_RUN);
  assign wr_ok  = tbl_wr_en && (state_q != S_RUN)
                && (int'(tbl_wr_addr) < DEPTH);

  // Pattern table; writable only while no sequence is running
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_ok) begin
      tbl_q[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  // FSM, index and pass counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
    end
  end

  // Next state: advance on accepted beats, stop aborts after the beat
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          pass_d  = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (last) begin
            pass_d = (&pass_q) ? pass_q : pass_q + 1'b1;
            idx_d  = '0;
            if (!loop_mode) begin
              state_d = S_DONE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          pass_d  = '0;
        end else if (stop) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign out_idx   = idx_q;
  assign pass_cnt  = pass_q;

`ifdef MC_PATTERN_SEQ_LFSR_EN
  logic              lfsr_on_q;
  logic [DATA_W-1:0] lfsr_val;
  logic [DATA_W-1:0] seed;

  // A same-cycle write to entry 0 must seed the LFSR too
  assign seed = (wr_ok && tbl_wr_addr == '0) ? tbl_wr_data : tbl_q[0];

  // Data source selection is captured when a sequence starts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_on_q <= 1'b0;
    end else if (go) begin
      lfsr_on_q <= lfsr_mode;
    end
  end

  mc_pattern_lfsr #(
    .W (DATA_W)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (go),
    .seed  (seed),
    .step  (accept),
    .value (lfsr_val)
  );

  assign out_data = lfsr_on_q ? lfsr_val : tbl_q[idx_q];
`else
  logic unused_go;
  assign unused_go = go;
  assign out_data  = tbl_q[idx_q];
`endif

endmodule
